multicycle_controller: RTL and testbench

//  Main sequencer for the multicycle RV32I core: one shared ALU and one unified instr/data memory, one step per clock.

---
 rtl/mc_ctrl_pkg.sv | 61 ++++++
 rtl/mc_alu_decoder.sv | 32 +++
 rtl/multicycle_controller.sv | 147 ++++++++++++++
 tb/tb_multicycle_controller.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Purpose: shared types and constants for the multicycle RV32I controller.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional feature macro used by the controller: MCCTRL_LUI_EN.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_LUI      = 4'd11,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // ALU operation class requested by the sequencer
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    // Immediate format is a pure function of the opcode; unknown ops fall back to I.
    function automatic logic [2:0] imm_src_for(input logic [6:0] op);
        logic [2:0] imm;
        imm = IMM_I;
        case (op)
            OP_STORE: imm = IMM_S;
            OP_BEQ:   imm = IMM_B;
            OP_JAL:   imm = IMM_J;
            OP_LUI:   imm = IMM_U;
            default:  imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Purpose: map ALU operation class plus funct fields to an ALUControl code.
// Latency: combinational, zero cycles.
// Backpressure: none; output always valid and never X for known inputs.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_op5,
    output logic [2:0] o_alu_control
);

    // Subtract on funct3=000 only for R-type sub; addi with IR[30] set stays add.
    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    3'b000:  o_alu_control = (i_funct7b5 & i_op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Purpose: main sequencer of the multicycle RV32I core; LUI support under macro MCCTRL_LUI_EN.
// Latency: one state per clock; datapath controls are combinational from the current state.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready; HALT is left only by reset.
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
)(
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ImmSrc,
    output logic [2:0]         ALUControl,
    output logic               halted,
    output logic [STATE_W-1:0] state_o
);

    state_t     r_state;
    logic [1:0] w_alu_op;

    // State register; async reset drops any in-flight access so a stalled store is never re-issued
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    r_state <= mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: r_state <= S_MEMADR;
                        OP_RTYPE:          r_state <= S_EXECR;
                        OP_ITYPE:          r_state <= S_EXECI;
                        OP_BEQ:            r_state <= S_BEQ;
                        OP_JAL:            r_state <= S_JAL;
`ifdef MCCTRL_LUI_EN
                        OP_LUI:            r_state <= S_LUI;
`endif
                        default:           r_state <= S_HALT;
                    endcase
                end
                S_MEMADR:   r_state <= op[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  r_state <= mem_ready ? S_MEMWB : S_MEMREAD;
                S_MEMWB:    r_state <= S_FETCH;
                S_MEMWRITE: r_state <= mem_ready ? S_FETCH : S_MEMWRITE;
                S_EXECR:    r_state <= S_ALUWB;
                S_EXECI:    r_state <= S_ALUWB;
                S_ALUWB:    r_state <= S_FETCH;
                S_JAL:      r_state <= S_ALUWB;
                S_BEQ:      r_state <= S_FETCH;
`ifdef MCCTRL_LUI_EN
                S_LUI:      r_state <= S_ALUWB;
`endif
                default:    r_state <= S_HALT;
            endcase
        end
    end

    // Datapath enables and mux selects decoded from the current state
    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        w_alu_op  = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA  = 2'b10;
                w_alu_op = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = ALUOP_FUNCT;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                w_alu_op = ALUOP_SUB;
                PCWrite  = Zero;
            end
`ifdef MCCTRL_LUI_EN
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
            end
`endif
            default: ;
        endcase
    end

    mc_alu_decoder u_alu_dec (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_funct7b5    (funct7b5),
        .i_op5         (op[5]),
        .o_alu_control (ALUControl)
    );

    assign ImmSrc  = imm_src_for(op);
    assign halted  = (r_state == S_HALT);
    assign state_o = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_controller.sv
// Purpose: self-checking bench for multicycle_controller (reference model plus directed literals).
// Latency: model follows the one-state-per-clock sequencing rules.
// Backpressure: exercises mem_ready stalls in FETCH and MEMWRITE.
module tb_multicycle_controller;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
    logic        mr;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;

    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, halted;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0]  ImmSrc, ALUControl;
    logic [3:0]  state_o;

    int n_pass  = 0;
    int n_total = 0;
    bit done    = 0;

`ifdef MCCTRL_LUI_EN
    localparam bit LUI_EN = 1'b1;
`else
    localparam bit LUI_EN = 1'b0;
`endif

    assign op       = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7b5 = instr[30];

    multicycle_controller #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (zero),
        .mem_ready  (mr),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .halted     (halted),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h expected=0x%0h", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    int m_state = 0;

    function automatic int model_next(input int s);
        case (s)
            0:  return mr ? 1 : 0;
            1: begin
                if (op == 7'h03 || op == 7'h23) return 2;
                if (op == 7'h33) return 6;
                if (op == 7'h13) return 8;
                if (op == 7'h63) return 10;
                if (op == 7'h6F) return 9;
                if (op == 7'h37 && LUI_EN) return 11;
                return 15;
            end
            2:  return op[5] ? 5 : 3;
            3:  return mr ? 4 : 3;
            5:  return mr ? 0 : 5;
            6, 8, 9, 11: return 7;
            4, 7, 10: return 0;
            default: return 15;
        endcase
    endfunction

    // Expected outputs packed as {pcw,adr,mw,irw,rw,rs[2],sa[2],sb[2],imm[3],alu[3],halted,state[4]}
    function automatic logic [21:0] model_out(input int s);
        logic pcw, adr, mw, irw, rw, hl;
        logic [1:0] rs, sa, sb;
        logic [2:0] imm, alu, fa;
        {pcw, adr, mw, irw, rw, hl} = '0;
        rs = 0; sa = 0; sb = 0; alu = 0;
        case (op)
            7'h23:   imm = 3'd1;
            7'h63:   imm = 3'd2;
            7'h6F:   imm = 3'd3;
            7'h37:   imm = 3'd4;
            default: imm = 3'd0;
        endcase
        case (funct3)
            3'd0:    fa = (funct7b5 && op[5]) ? 3'd1 : 3'd0;
            3'd2:    fa = 3'd5;
            3'd6:    fa = 3'd3;
            3'd7:    fa = 3'd2;
            default: fa = 3'd0;
        endcase
        case (s)
            0:  begin sb = 2; rs = 2; irw = mr; pcw = mr; end
            1:  begin sa = 1; sb = 1; end
            2:  begin sa = 2; sb = 1; end
            3:  adr = 1;
            4:  begin rs = 1; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin sa = 2; alu = fa; end
            7:  rw = 1;
            8:  begin sa = 2; sb = 1; alu = fa; end
            9:  begin sa = 1; sb = 2; pcw = 1; end
            10: begin sa = 2; alu = 1; pcw = zero; end
            11: begin sa = 3; sb = 1; end
            default: hl = 1;
        endcase
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, hl, 4'(s)};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m_state <= 0;
        else       m_state <= model_next(m_state);
    end

    // Compare every cycle just before the active edge, after all stimulus has settled
    always @(negedge clk) begin
        #4;
        if (!done)
            chk("model", {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                          ALUSrcB, ImmSrc, ALUControl, halted, state_o}, model_out(m_state));
    end

    // ---------------- directed stimulus ----------------
    function automatic int pick(input int sel);
        case (sel)
            0:       return int'(RegWrite);
            1:       return int'(MemWrite);
            2:       return int'(PCWrite);
            3:       return int'(ALUControl);
            default: return int'(halted);
        endcase
    endfunction

    // Entry between negedge and the next posedge in FETCH; ends in the last listed state.
    task automatic run(input string nm, input logic [31:0] ins, input logic z,
                       input int es[$], input int sel, input int ev[$]);
        instr = ins; zero = z; mr = 1'b1;
        #1;
        for (int i = 0; i < es.size(); i++) begin
            if (i > 0) begin @(negedge clk); #2; end
            chk({nm, " state"}, 32'(state_o), es[i]);
            chk({nm, " sig"}, pick(sel), ev[i]);
        end
    endtask

    task automatic pulse_reset(input string nm);
        reset = 1'b1;
        #1;
        chk({nm, " rst state"}, 32'(state_o), 0);
        chk({nm, " rst halted"}, 32'(halted), 0);
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; instr = 32'h0000_2083; zero = 1'b0; mr = 1'b1;
        #2;
        chk("reset state", 32'(state_o), 0);
        chk("reset halted", 32'(halted), 0);
        chk("reset memwrite", 32'(MemWrite), 0);
        chk("reset regwrite", 32'(RegWrite), 0);
        @(negedge clk); #1;
        reset = 1'b0;

        run("lw",   32'h0000_2083, 1'b0, '{0,1,2,3,4,0}, 0, '{0,0,0,0,1,0});
        run("sw",   32'h0020_2223, 1'b0, '{0,1,2,5,0},   1, '{0,0,0,1,0});
        run("beq1", 32'h0000_0063, 1'b1, '{0,1,10,0},    2, '{1,0,1,1});
        run("beq0", 32'h0000_0063, 1'b0, '{0,1,10,0},    2, '{1,0,0,1});
        run("jal",  32'h0000_006F, 1'b0, '{0,1,9,7,0},   2, '{1,0,1,0,1});
        run("sub",  32'h4020_8033, 1'b0, '{0,1,6,7,0},   3, '{0,0,1,0,0});
        run("slt",  32'h0020_A033, 1'b0, '{0,1,6,7,0},   3, '{0,0,5,0,0});
        run("or",   32'h0020_E033, 1'b0, '{0,1,6,7,0},   3, '{0,0,3,0,0});
        run("and",  32'h0020_F033, 1'b0, '{0,1,6,7,0},   3, '{0,0,2,0,0});
        run("sll",  32'h0020_9033, 1'b0, '{0,1,6,7,0},   3, '{0,0,0,0,0});
        run("addi", 32'h4000_8093, 1'b0, '{0,1,8,7,0},   3, '{0,0,0,0,0});

        // FETCH stall: three cycles without mem_ready, then a single fetch
        instr = 32'h0000_2083; mr = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin @(negedge clk); #2; end
            chk("stall state", 32'(state_o), 0);
            chk("stall irwrite", 32'(IRWrite), 0);
            chk("stall pcwrite", 32'(PCWrite), 0);
        end
        @(negedge clk); #2;
        mr = 1'b1;
        #1;
        chk("fetch irwrite", 32'(IRWrite), 1);
        @(negedge clk); #2;
        chk("fetch next", 32'(state_o), 1);
        chk("fetch irwrite off", 32'(IRWrite), 0);
        repeat (4) @(negedge clk);
        #2;
        chk("stall return", 32'(state_o), 0);

        // Illegal opcode halts until reset
        run("ill", 32'h0000_007F, 1'b0, '{0,1,15}, 4, '{0,0,1});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #2;
            chk("halt state", 32'(state_o), 15);
            chk("halt flag", 32'(halted), 1);
        end
        pulse_reset("ill");

`ifdef MCCTRL_LUI_EN
        run("lui", 32'h0000_0037, 1'b0, '{0,1,11,7,0}, 3, '{0,0,0,0,0});
`else
        run("lui", 32'h0000_0037, 1'b0, '{0,1,15}, 4, '{0,0,1});
        @(negedge clk); #2;
        chk("lui halted", 32'(halted), 1);
        pulse_reset("lui");
`endif

        // Reset while a store is stalled waiting for memory
        run("swr", 32'h0020_2223, 1'b0, '{0,1,2,5}, 1, '{0,0,0,1});
        mr = 1'b0;
        @(negedge clk); #2;
        chk("store stalled", 32'(state_o), 5);
        chk("store strobe", 32'(MemWrite), 1);
        reset = 1'b1;
        #1;
        chk("mid rst memwrite", 32'(MemWrite), 0);
        chk("mid rst state", 32'(state_o), 0);
        @(negedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #2;
            chk("post rst memwrite", 32'(MemWrite), 0);
            chk("post rst state", 32'(state_o), 0);
        end

        @(negedge clk); #2;
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
